prog_loader: RTL and testbench
==============================

# prog_loader

Streaming program loader that writes an 8-bit instruction image into the CPU's instruction/data memory while holding the CPU off, then releases it. It is the writer side of the memory the CPU sequencer reads during INST_ADDR/INST_FETCH/INST_LOAD. Instruction words use the CPU opcode encoding: bits [7:5] carry the opcode (HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP=7), and bits [4:0] carry the operand address. Each load is verified with a trailing XOR checksum and a check for at least one HLT instruction.

## Interface
- DATA_W, 8: instruction word width, equal to the CPU default word width.
- OPCODE_W, 3: opcode field width, located at the top of the word.
- ADDR_W, 5: memory address width; capacity is 2^ADDR_W words.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  stream byte accepted when in_valid & in_ready are both high.
- in_data  in  DATA_W  instruction byte, or the checksum byte when in_last=1.
- in_last  in  1  marks the checksum trailer; that byte is never written to memory.
- mem_wr  out  1  memory write strobe; a one-cycle pulse per word.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  DATA_W  write data.
- cpu_hold  out  1  holds the CPU in reset while high.
- done  out  1  load succeeded; level signal.
- err  out  1  load failed; level signal.
- err_code  out  2  0 = none, 1 = checksum mismatch, 2 = overflow, 3 = no HLT.
- word_count  out  ADDR_W+1  number of words written in the current or last load.

## Operation
- States:
  - IDLE: reached from reset.
  - LOAD.
  - DONE.
  - ERROR.
- Reset values:
  - State = IDLE.
  - cpu_hold = 1.
  - in_ready = 0, mem_wr = 0, mem_addr = 0, mem_data = 0.
  - done = 0, err = 0, err_code = 0, word_count = 0.
  - Internal pointer, checksum and hlt_seen = 0.
- start in IDLE, DONE or ERROR moves to LOAD. It also sets:
  - pointer = 0, checksum = 0, hlt_seen = 0, word_count = 0.
  - done = 0, err = 0, err_code = 0.
  - cpu_hold = 1 and in_ready = 1.
- start while in LOAD is ignored.
- Data beat in LOAD (handshake with in_last=0 and word_count < 2^ADDR_W):
  - Write in_data to address pointer.
  - pointer += 1, word_count += 1.
  - checksum ^= in_data.
  - hlt_seen |= (in_data[7:5] == 0).
- Overflow beat: handshake with in_last=0 and word_count == 2^ADDR_W.
  - The byte is not written.
  - Next state is ERROR with err_code = 2.
- Trailer beat: handshake with in_last=1. Next state is chosen by priority:
  - checksum != in_data → ERROR, err_code = 1.
  - else hlt_seen == 0 (including an empty program) → ERROR, err_code = 3.
  - else → DONE.
- DONE: done = 1, cpu_hold = 0, in_ready = 0.
- ERROR: err = 1, cpu_hold = 1, in_ready = 0.
- DONE and ERROR are held until start or rst.
- Reset mid-load: every output returns to its reset value immediately (asynchronously). Memory is left partially written; no rollback.
- Words are written at addresses 0 through word_count-1. Pointer wrap cannot occur because of the overflow check.

## Timing
- in_ready is registered:
  - It rises the cycle after start.
  - It stays high throughout LOAD.
  - It falls the cycle after the trailer or overflow handshake.
- mem_wr pulses in the cycle after each data-beat handshake; mem_addr and mem_data are valid in that same cycle. Back-to-back handshakes give back-to-back write pulses.
- Cycles with in_valid=0 produce no write and no state change.
- done or err, and the cpu_hold change, appear in the cycle after the trailer handshake.
- Throughput: 1 word per cycle.

## Test plan
- Nominal load: start, then stream 0xBA (LDA 0x1A), 0x41 (ADD 0x01), 0xDB (STO 0x1B), 0x00 (HLT), and trailer 0x20 with in_last=1.
  - Writes at addr 0..3 with those bytes.
  - word_count = 4.
  - One cycle after the trailer: done = 1, cpu_hold = 0, in_ready = 0.
- Checksum error: same stream but trailer 0x21.
  - err = 1, err_code = 1, cpu_hold stays 1.
  - The four writes still occurred.
- No HLT: stream 0xBA, 0x41, trailer 0xFB → err_code = 3.
  - Separately, an empty program (trailer 0x00 first) → err_code = 3, word_count = 0.
- Overflow (ADDR_W=5): 33 data beats with no in_last.
  - 32 writes at addresses 0..31.
  - The 33rd byte is not written.
  - err_code = 2, word_count = 32.
- Backpressure and restart:
  - Nominal stream with in_valid toggling 1,0,0,1,… → no mem_wr on idle cycles, same final result as the nominal load.
  - A start pulse mid-load is ignored.
  - A start in DONE re-raises cpu_hold the next cycle and clears done.
- Reset mid-load: assert rst after 2 data beats.
  - Same cycle: mem_wr = 0, in_ready = 0, cpu_hold = 1, word_count = 0.
  - After rst is released, state is IDLE; a subsequent nominal load succeeds.

Source files
------------

// File: rtl/prog_loader.sv
// Streaming program loader: writes an instruction image into CPU memory while
// holding the CPU in reset, then verifies the XOR checksum trailer and HLT presence.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset; CPU held, stream not accepted
// S_LOAD  | accepting data beats and writing memory; waiting for trailer
// S_DONE  | image verified; CPU released
// S_ERROR | checksum, overflow or missing-HLT failure; CPU held
module prog_loader #(
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 3,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

    localparam logic [ADDR_W:0] CAPACITY = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_OVFL = 2'd2;
    localparam logic [1:0] ERR_NHLT = 2'd3;

    state_t              state_q, state_nxt;
    logic [ADDR_W-1:0]   ptr_q, ptr_nxt;
    logic [DATA_W-1:0]   csum_q, csum_nxt;
    logic                hlt_q, hlt_nxt;
    logic [ADDR_W:0]     wc_nxt;
    logic                in_ready_nxt, mem_wr_nxt, hold_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_data_nxt;
    logic [1:0]          code_nxt;
    logic                beat;

    assign beat = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            csum_q     <= '0;
            hlt_q      <= 1'b0;
            word_count <= '0;
            in_ready   <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state_q    <= state_nxt;
            ptr_q      <= ptr_nxt;
            csum_q     <= csum_nxt;
            hlt_q      <= hlt_nxt;
            word_count <= wc_nxt;
            in_ready   <= in_ready_nxt;
            mem_wr     <= mem_wr_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_data   <= mem_data_nxt;
            cpu_hold   <= hold_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            err_code   <= code_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        ptr_nxt      = ptr_q;
        csum_nxt     = csum_q;
        hlt_nxt      = hlt_q;
        wc_nxt       = word_count;
        in_ready_nxt = in_ready;
        mem_wr_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        mem_data_nxt = mem_data;
        hold_nxt     = cpu_hold;
        done_nxt     = done;
        err_nxt      = err;
        code_nxt     = err_code;
        case (state_q)
            S_LOAD: begin
                if (beat && !in_last) begin
                    if (word_count == CAPACITY) begin
                        // the extra byte is dropped; memory already holds a full image
                        state_nxt    = S_ERROR;
                        in_ready_nxt = 1'b0;
                        err_nxt      = 1'b1;
                        code_nxt     = ERR_OVFL;
                    end else begin
                        mem_wr_nxt   = 1'b1;
                        mem_addr_nxt = ptr_q;
                        mem_data_nxt = in_data;
                        ptr_nxt      = ptr_q + 1'b1;
                        wc_nxt       = word_count + 1'b1;
                        csum_nxt     = csum_q ^ in_data;
                        hlt_nxt      = hlt_q | (in_data[DATA_W-1 -: OPCODE_W] == '0);
                    end
                end else if (beat) begin
                    in_ready_nxt = 1'b0;
                    if (csum_q != in_data) begin
                        state_nxt = S_ERROR;
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_CSUM;
                    end else if (!hlt_q) begin
                        state_nxt = S_ERROR;
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_NHLT;
                    end else begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                        hold_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nxt    = S_LOAD;
                    ptr_nxt      = '0;
                    csum_nxt     = '0;
                    hlt_nxt      = 1'b0;
                    wc_nxt       = '0;
                    done_nxt     = 1'b0;
                    err_nxt      = 1'b0;
                    code_nxt     = ERR_NONE;
                    hold_nxt     = 1'b1;
                    in_ready_nxt = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random loads checked against a
// behavioural model of the expected writes and final status.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_hold, done, err;
    logic [1:0] err_code;
    logic [5:0] word_count;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]  prog [0:63];
    int          prog_len;
    logic [12:0] wq [$];

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data(mem_data), .cpu_hold(cpu_hold), .done(done), .err(err),
        .err_code(err_code), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && mem_wr === 1'b1) wq.push_back({mem_addr, mem_data});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: expected outcome follows directly from the byte list and trailer.
    task automatic run_load(input logic [7:0] trailer, input bit bp, input bit mid_start);
        int   exp_wc, exp_code, n_send, n_beats, k, lim;
        logic [7:0] x;
        bit   h;
        if (prog_len > 32) begin
            exp_wc = 32; exp_code = 2; n_send = 33; n_beats = 33;
        end else begin
            x = 8'h00; h = 1'b0;
            for (int i = 0; i < prog_len; i++) begin
                x = x ^ prog[i];
                if (prog[i] < 8'h20) h = 1'b1;
            end
            exp_wc = prog_len; n_send = prog_len; n_beats = prog_len + 1;
            exp_code = (x != trailer) ? 1 : (!h ? 3 : 0);
        end

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_in_ready", in_ready, 1);
        check("start_cpu_hold", cpu_hold, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", {err, err_code}, 0);
        check("start_wc_clr", word_count, 0);
        wq.delete();

        for (int i = 0; i < n_beats; i++) begin
            k = bp ? int'($urandom_range(0, 2)) : 0;
            if (mid_start && i == 1 && k == 0) k = 1;
            for (int j = 0; j < k; j++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                start    = mid_start && i == 1 && j == 0;
                @(negedge clk);
                start = 1'b0;
            end
            in_valid = 1'b1;
            if (i < n_send) begin
                in_data = prog[i]; in_last = 1'b0;
            end else begin
                in_data = trailer; in_last = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        check("end_done", done, exp_code == 0);
        check("end_err", err, exp_code != 0);
        check("end_err_code", err_code, exp_code);
        check("end_cpu_hold", cpu_hold, exp_code != 0);
        check("end_in_ready", in_ready, 0);
        check("end_word_count", word_count, exp_wc);

        @(negedge clk);
        @(negedge clk);
        check("write_count", wq.size(), exp_wc);
        lim = (wq.size() < exp_wc) ? wq.size() : exp_wc;
        for (int i = 0; i < lim; i++)
            check($sformatf("write_%0d", i), wq[i], {i[4:0], prog[i]});
        check("held_status", {done, err, err_code}, {exp_code == 0, exp_code != 0, exp_code[1:0]});
    endtask

    task automatic set_nominal();
        prog[0] = 8'hBA; prog[1] = 8'h41; prog[2] = 8'hDB; prog[3] = 8'h00;
        prog_len = 4;
    endtask

    initial begin
        logic [7:0] x;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr_data", {mem_addr, mem_data}, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_status", {done, err, err_code}, 0);
        check("rst_word_count", word_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);

        set_nominal();
        run_load(8'h20, 1'b0, 1'b0);
        run_load(8'h21, 1'b0, 1'b0);
        prog_len = 2;
        run_load(8'hFB, 1'b0, 1'b0);
        prog_len = 0;
        run_load(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 33; i++) prog[i] = 8'($urandom);
        prog_len = 33;
        run_load(8'h00, 1'b0, 1'b0);
        set_nominal();
        run_load(8'h20, 1'b1, 1'b1);

        // reset after two data beats, while the second write is on the bus
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        in_valid = 1'b1; in_data = 8'hBA;
        @(negedge clk) in_data = 8'h41;
        @(negedge clk) in_valid = 1'b0;
        check("pre_rst_mem_wr", mem_wr, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_mem_wr", mem_wr, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_cpu_hold", cpu_hold, 1);
        check("mid_rst_word_count", word_count, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {in_ready, cpu_hold, done, err}, 4'b0100);
        run_load(8'h20, 1'b0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            prog_len = int'($urandom_range(1, 20));
            x = 8'h00;
            for (int i = 0; i < prog_len; i++) prog[i] = 8'($urandom) | 8'h20;
            if ($urandom_range(0, 2) != 0) begin
                int idx;
                idx = int'($urandom_range(0, prog_len - 1));
                prog[idx] = prog[idx] & 8'h1F;
            end
            for (int i = 0; i < prog_len; i++) x = x ^ prog[i];
            if ($urandom_range(0, 3) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
            run_load(x, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
